// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder whose carry chain is cut into STAGES registered slices, with valid/ready flow control.
// Optional signed-overflow output is enabled by defining PIPELINED_CARRY_ADDER_OVF_EN.
module pipelined_carry_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SLICE = (STAGES == 0) ? 1 : WIDTH / STAGES;
    localparam int unsigned LAST  = (STAGES == 0) ? 0 : STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : gen_bad_params
        $error("pipelined_carry_adder: WIDTH must be >= 2 and a multiple of STAGES (1..WIDTH)");
    end

    // Full-adder ripple across one slice; returns {carry_out, slice_sum}.
    function automatic logic [SLICE:0] ripple(input logic [SLICE-1:0] x,
                                              input logic [SLICE-1:0] y,
                                              input logic             ci);
        logic [SLICE-1:0] s;
        logic             c;
        c = ci;
        s = '0;
        for (int i = 0; i < int'(SLICE); i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Stage registers: operands travel with the partial sum so higher slices meet their carry.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];

    logic [STAGES-1:0] c_d;
    logic [WIDTH-1:0]  s_d [STAGES];

    logic stall;

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // Stage 0 is fed from the ports, every other stage from the previous stage's register.
    always_comb begin
        v_in    = '0;
        c_in    = '0;
        v_in[0] = in_valid;
        c_in[0] = cin;
        a_in[0] = a;
        b_in[0] = b;
        s_in[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            v_in[k] = v_q[k-1];
            c_in[k] = c_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
        end
    end

    always_comb begin
        c_d = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            logic [SLICE:0] res;
            res    = ripple(a_in[k][k*SLICE +: SLICE], b_in[k][k*SLICE +: SLICE], c_in[k]);
            s_d[k] = s_in[k];
            s_d[k][k*SLICE +: SLICE] = res[SLICE-1:0];
            c_d[k] = res[SLICE];
        end
    end

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                   (s_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
    assign ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_d;
        end
    end
`endif

    // Global stall: the whole pipe, valid bits included, freezes while the output is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q <= v_in;
            c_q <= c_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder at WIDTH=16, STAGES=4.
// Define PIPELINED_CARRY_ADDER_OVF_EN to also exercise the overflow output.
module tb_pipelined_carry_adder;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    logic         ovf;
`endif

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    pipelined_carry_adder #(
        .WIDTH (16),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t         r;
        logic [W:0]   t;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    // Drive one cycle's inputs on the falling edge, then let combinational outputs settle.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic ci, input logic ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        a         = aa;
        b         = bb;
        cin       = ci;
        out_ready = ordy;
        #1;
    endtask

    task automatic push_if_accepted();
        if (in_valid && in_ready && !rst) q.push_back(model(a, b, cin));
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 16'hffff, 16'hffff, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (sum !== 16'h0000) begin
            n_bad++; $display("FAIL reset_sum: got %h want 0000", sum);
        end
        n_cmp++;
        if (cout !== 1'b0) begin
            n_bad++; $display("FAIL reset_cout: got %b want 0", cout);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_add();
        step(0, 1, 16'h1234, 16'h4321, 0, 1);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL single_in_ready: got %b want 1", in_ready);
        end
        for (int n = 1; n <= 6; n++) begin
            step(0, 0, 0, 0, 0, 1);
            n_cmp++;
            if (out_valid !== (n == 4)) begin
                n_bad++; $display("FAIL single_latency c%0d: out_valid got %b want %b",
                                  n, out_valid, (n == 4));
            end
            if (n == 4) begin
                n_cmp++;
                if (sum !== 16'h5555 || cout !== 1'b0) begin
                    n_bad++; $display("FAIL single_sum: got %h/%b want 5555/0", sum, cout);
                end
            end
        end
    endtask

    task automatic test_carry_ripple();
        logic [W-1:0] va [6] = '{16'hffff, 16'hffff, 16'h000f, 16'h00ff, 16'h0fff, 16'h7fff};
        logic [W-1:0] vb [6] = '{16'h0000, 16'hffff, 16'h0001, 16'h0001, 16'h0001, 16'h8000};
        logic         vc [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6 + 12; i++) begin
            if (i < 6) step(0, 1, va[i], vb[i], vc[i], 1);
            else step(0, 0, 0, 0, 0, 1);
            push_if_accepted();
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL ripple_extra: unexpected sum %h", sum);
                end else begin
                    e = q.pop_front();
                    if (sum !== e.s || cout !== e.c) begin
                        n_bad++; $display("FAIL ripple_sum: got %h/%b want %h/%b",
                                          sum, cout, e.s, e.c);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL ripple_drain: %0d results missing, want 0", q.size());
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int nout;
        c0   = 0;
        nout = 0;
        for (int i = 0; i < 20 + 12; i++) begin
            if (i < 20) step(0, 1, W'($urandom()), W'($urandom()), 1'($urandom()), 1);
            else step(0, 0, 0, 0, 0, 1);
            if (i == 0) c0 = cyc;
            push_if_accepted();
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra: unexpected sum %h", sum);
                end else begin
                    e = q.pop_front();
                    if (sum !== e.s || cout !== e.c) begin
                        n_bad++; $display("FAIL b2b_sum #%0d: got %h/%b want %h/%b",
                                          nout, sum, cout, e.s, e.c);
                    end
                end
                n_cmp++;
                if (cyc != c0 + 4 + nout) begin
                    n_bad++; $display("FAIL b2b_timing #%0d: cycle got %0d want %0d",
                                      nout, cyc, c0 + 4 + nout);
                end
                nout++;
            end
        end
        n_cmp++;
        if (nout != 20 || q.size() != 0) begin
            n_bad++; $display("FAIL b2b_count: got %0d results want 20", nout);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_s;
        logic         held_c;
        logic         ordy;
        held_s = '0;
        held_c = 1'b0;
        for (int i = 0; i < 9 + 14; i++) begin
            ordy = !(i >= 6 && i < 9);
            if (i < 9) step(0, 1, W'($urandom()), W'($urandom()), 1'($urandom()), ordy);
            else step(0, 0, 0, 0, 0, 1);
            push_if_accepted();
            if (!ordy) begin
                n_cmp++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_bad++; $display("FAIL bp_stall: in_ready/out_valid got %b/%b want 0/1",
                                      in_ready, out_valid);
                end
                if (i == 6) begin
                    held_s = sum;
                    held_c = cout;
                end else begin
                    n_cmp++;
                    if (sum !== held_s || cout !== held_c) begin
                        n_bad++; $display("FAIL bp_hold: got %h/%b want %h/%b",
                                          sum, cout, held_s, held_c);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra: unexpected sum %h", sum);
                end else begin
                    e = q.pop_front();
                    if (sum !== e.s || cout !== e.c) begin
                        n_bad++; $display("FAIL bp_sum: got %h/%b want %h/%b",
                                          sum, cout, e.s, e.c);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL bp_drain: %0d results missing, want 0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 16'h1111, 16'h2222, 0, 1);
        step(0, 1, 16'h3333, 16'h4444, 1, 1);
        step(0, 1, 16'hffff, 16'h0001, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_clear: got v=%b %h/%b want v=0 0000/0",
                              out_valid, sum, cout);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 1);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++; $display("FAIL rstmid_ghost c%0d: out_valid got %b want 0", i, out_valid);
            end
        end
    endtask

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] va [3] = '{16'h7fff, 16'h8000, 16'h0001};
        logic [W-1:0] vb [3] = '{16'h0001, 16'hffff, 16'h0001};
        for (int i = 0; i < 3 + 10; i++) begin
            if (i < 3) step(0, 1, va[i], vb[i], 0, 1);
            else step(0, 0, 0, 0, 0, 1);
            push_if_accepted();
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL ovf_extra: unexpected sum %h", sum);
                end else begin
                    e = q.pop_front();
                    if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
                        n_bad++; $display("FAIL ovf_sum: got %h/%b/%b want %h/%b/%b",
                                          sum, cout, ovf, e.s, e.c, e.o);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL ovf_drain: %0d results missing, want 0", q.size());
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single_add();
        test_carry_ripple();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d cycles", cyc);
        $fatal(1, "timeout");
    end

endmodule
